// File: rtl/inst_encoder_pkg.sv
// rtl/inst_encoder_pkg.sv - shared opcodes, formats, error codes and FSM states
package inst_encoder_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_ILLEGAL
  } fmt_e;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_OPCODE = 2'b01;
  localparam logic [1:0] ERR_RANGE  = 2'b10;
  localparam logic [1:0] ERR_ODD    = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FULL,
    ST_HALT
  } state_e;

  // Map a 7-bit opcode onto the encoding format it uses
  function automatic fmt_e decode_fmt(input logic [6:0] opcode);
    case (opcode)
      OPC_LOAD, OPC_OP_IMM: decode_fmt = FMT_I;
      OPC_STORE:            decode_fmt = FMT_S;
      OPC_BRANCH:           decode_fmt = FMT_B;
      default:              decode_fmt = FMT_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// rtl/inst_encoder_pack.sv - combinational field packer with range and alignment flags
module inst_pack
  import inst_encoder_pkg::*;
(
  input  fmt_e        fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] inst_o,
  output logic        range_ok_o,
  output logic        odd_o
);

  logic fits12;
  logic fits13;

  // A value fits in N signed bits when every bit above N-2 matches the sign
  assign fits12 = (~|imm_i[31:11]) | (&imm_i[31:11]);
  assign fits13 = (~|imm_i[31:12]) | (&imm_i[31:12]);

  // Scatter the fields into the word layout of the selected format
  always_comb begin
    inst_o     = '0;
    range_ok_o = 1'b0;
    odd_o      = 1'b0;
    case (fmt_i)
      FMT_I: begin
        inst_o     = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        range_ok_o = fits12;
      end
      FMT_S: begin
        inst_o     = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        range_ok_o = fits12;
      end
      FMT_B: begin
        inst_o     = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                      imm_i[4:1], imm_i[11], opcode_i};
        range_ok_o = fits13;
        odd_o      = imm_i[0];
      end
      default: begin
        inst_o     = '0;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - instruction encoder with output register, address counter and error halt
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [1:0]  err_code
);

  state_e      state_q;
  logic        out_valid_q;
  logic [31:0] out_inst_q;
  logic [31:0] out_addr_q;
  logic        err_q;
  logic [1:0]  err_code_q;

  fmt_e        fmt;
  logic [31:0] word;
  logic        range_ok;
  logic        odd;
  logic [1:0]  err_code_d;
  logic        in_hs;
  logic        out_hs;

  assign fmt = decode_fmt(in_opcode);

  inst_pack u_pack (
    .fmt_i      (fmt),
    .opcode_i   (in_opcode),
    .funct3_i   (in_funct3),
    .rd_i       (in_rd),
    .rs1_i      (in_rs1),
    .rs2_i      (in_rs2),
    .imm_i      (in_imm),
    .inst_o     (word),
    .range_ok_o (range_ok),
    .odd_o      (odd)
  );

  // Classify the incoming bundle; opcode outranks range, range outranks alignment
  always_comb begin
    err_code_d = ERR_NONE;
    if (fmt == FMT_ILLEGAL) begin
      err_code_d = ERR_OPCODE;
    end else if (!range_ok) begin
      err_code_d = ERR_RANGE;
    end else if (odd) begin
      err_code_d = ERR_ODD;
    end
  end

  // Accept when the output slot is free or being drained this cycle; never during rst or clr
  assign in_ready = !rst && !clr &&
                    ((state_q == ST_EMPTY) || ((state_q == ST_FULL) && out_ready));
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  // FSM, output register and address counter; address advances on every output handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_addr_q  <= BASE_ADDR;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else if (clr) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      out_addr_q  <= BASE_ADDR;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      if (out_hs) begin
        out_addr_q <= out_addr_q + 32'd4;
      end
      case (state_q)
        ST_EMPTY, ST_FULL: begin
          if (in_hs) begin
            if (err_code_d == ERR_NONE) begin
              out_inst_q  <= word;
              out_valid_q <= 1'b1;
              state_q     <= ST_FULL;
            end else begin
              out_valid_q <= 1'b0;
              err_q       <= 1'b1;
              err_code_q  <= err_code_d;
              state_q     <= ST_HALT;
            end
          end else if (out_hs) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_HALT: begin
          out_valid_q <= 1'b0;
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_EMPTY;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_addr  = out_addr_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - scoreboard bench for inst_encoder
module tb_inst_encoder;

  localparam logic [31:0] BASE = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        err;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_addr = BASE;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  bit          done = 1'b0;

  inst_encoder #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Inputs change 1 unit after posedge, so a negedge sample predicts the next edge's handshake
  always @(negedge clk) begin
    if (!rst && !clr && out_valid && out_ready) got_q.push_back({out_inst, out_addr});
  end

  function automatic logic [31:0] model_word(input logic [6:0] opc, input logic [2:0] f3,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    case (opc)
      7'b0000011, 7'b0010011: model_word = {imm[11:0], rs1, f3, rd, opc};
      7'b0100011: model_word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      default:    model_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
    endcase
  endfunction

  task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    int n = 0;
    in_opcode = opc; in_funct3 = f3; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready=%0b required 1 within 200 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_got(output bit ok);
    int n = 0;
    while (got_q.size() == 0 && n < 200) begin @(negedge clk); n++; end
    ok = (got_q.size() != 0);
  endtask

  task automatic clr_pulse();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    exp_addr = BASE;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_checks += 6;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    if (out_inst !== 32'h0) begin n_fail++; $display("FAIL rst_out_inst: got %h want 0", out_inst); end
    if (out_addr !== BASE) begin n_fail++; $display("FAIL rst_out_addr: got %h want %h", out_addr, BASE); end
    if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0b want 0", err); end
    if (err_code !== 2'b00) begin n_fail++; $display("FAIL rst_err_code: got %0b want 00", err_code); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_formats();
    bit ok;
    logic [63:0] e, g;
    @(posedge clk); #1 out_ready = 1'b1;
    exp_q.push_back({32'h00500093, exp_addr});
    send(7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    @(negedge clk);
    n_checks += 3;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid: got %0b want 1", out_valid); end
    if (out_inst !== 32'h00500093) begin n_fail++; $display("FAIL lat_inst: got %h want 00500093", out_inst); end
    if (out_addr !== exp_addr) begin n_fail++; $display("FAIL lat_addr: got %h want %h", out_addr, exp_addr); end
    @(posedge clk); #1;
    exp_q.push_back({32'h0020A423, exp_addr + 32'd4});
    send(7'b0100011, 3'b010, 5'd0, 5'd1, 5'd2, 32'd8);
    exp_q.push_back({32'hFE208EE3, exp_addr + 32'd8});
    send(7'b1100011, 3'd0, 5'd0, 5'd1, 5'd2, -32'sd4);
    exp_addr = exp_addr + 32'd12;
    while (exp_q.size() > 0) begin
      wait_got(ok); e = exp_q.pop_front(); n_checks++;
      if (!ok) begin n_fail++; $display("FAIL fmt_timeout: no output, want %h", e); end
      else begin g = got_q.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL fmt_word: got %h want %h", g, e); end end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [63:0] e, g;
    logic [31:0] wa;
    @(posedge clk); #1 out_ready = 1'b0;
    wa = model_word(7'b0000011, 3'b010, 5'd3, 5'd4, 5'd0, 32'h7FF);
    exp_q.push_back({wa, exp_addr}); exp_addr += 4;
    send(7'b0000011, 3'b010, 5'd3, 5'd4, 5'd0, 32'h7FF);
    in_opcode = 7'b0100011; in_imm = 32'hFFFF_F800; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks += 3;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %0b want 1", out_valid); end
      if (out_inst !== wa) begin n_fail++; $display("FAIL bp_stable: got %h want %h", out_inst, wa); end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    exp_q.push_back({model_word(7'b0100011, 3'b001, 5'd0, 5'd7, 5'd9, 32'hFFFF_F800), exp_addr}); exp_addr += 4;
    send(7'b0100011, 3'b001, 5'd0, 5'd7, 5'd9, 32'hFFFF_F800);
    exp_q.push_back({model_word(7'b1100011, 3'b101, 5'd0, 5'd31, 5'd17, 32'd4094), exp_addr}); exp_addr += 4;
    send(7'b1100011, 3'b101, 5'd0, 5'd31, 5'd17, 32'd4094);
    while (exp_q.size() > 0) begin
      wait_got(ok); e = exp_q.pop_front(); n_checks++;
      if (!ok) begin n_fail++; $display("FAIL b2b_timeout: no output, want %h", e); end
      else begin g = got_q.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL b2b_word: got %h want %h", g, e); end end
    end
  endtask

  task automatic test_errors();
    bit ok;
    logic [63:0] e, g;
    logic [6:0]  t_opc[5]  = '{7'b1100011, 7'b0110111, 7'b0110111, 7'b1100011, 7'b0100011};
    logic [31:0] t_imm[5]  = '{32'd3, 32'd0, 32'd5000, 32'd4097, 32'hFFFF_F7FF};
    logic [1:0]  t_code[5] = '{2'b11, 2'b01, 2'b01, 2'b10, 2'b10};
    @(posedge clk); #1 out_ready = 1'b0;
    exp_q.push_back({model_word(7'b0010011, 3'b111, 5'd5, 5'd6, 5'd0, 32'hFFFF_F800), exp_addr});
    send(7'b0010011, 3'b111, 5'd5, 5'd6, 5'd0, 32'hFFFF_F800);
    out_ready = 1'b1;
    send(7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    @(negedge clk);
    n_checks += 4;
    if (err !== 1'b1) begin n_fail++; $display("FAIL range_err: got %0b want 1", err); end
    if (err_code !== 2'b10) begin n_fail++; $display("FAIL range_code: got %0b want 10", err_code); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL range_valid: got %0b want 0", out_valid); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL range_ready: got %0b want 0", in_ready); end
    wait_got(ok); e = exp_q.pop_front(); n_checks++;
    if (!ok) begin n_fail++; $display("FAIL drain_with_err: no output, want %h", e); end
    else begin g = got_q.pop_front();
      if (g !== e) begin n_fail++; $display("FAIL drain_with_err: got %h want %h", g, e); end end
    in_opcode = 7'b0010011; in_imm = 32'd1; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk); n_checks += 2;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL halt_ready: got %0b want 0", in_ready); end
      if (err !== 1'b1) begin n_fail++; $display("FAIL halt_err: got %0b want 1", err); end
    end
    @(posedge clk); #1 in_valid = 1'b0;
    clr_pulse();
    @(negedge clk); n_checks += 2;
    if (err !== 1'b0) begin n_fail++; $display("FAIL clr_err: got %0b want 0", err); end
    if (err_code !== 2'b00) begin n_fail++; $display("FAIL clr_code: got %0b want 00", err_code); end
    @(posedge clk); #1;
    exp_q.push_back({model_word(7'b1100011, 3'b001, 5'd0, 5'd2, 5'd3, 32'd6), exp_addr}); exp_addr += 4;
    send(7'b1100011, 3'b001, 5'd0, 5'd2, 5'd3, 32'd6);
    wait_got(ok); e = exp_q.pop_front(); n_checks++;
    if (!ok) begin n_fail++; $display("FAIL b_even: no output, want %h", e); end
    else begin g = got_q.pop_front();
      if (g !== e) begin n_fail++; $display("FAIL b_even: got %h want %h", g, e); end end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      send(t_opc[i], 3'd0, 5'd1, 5'd1, 5'd1, t_imm[i]);
      @(negedge clk); n_checks += 3;
      if (err !== 1'b1) begin n_fail++; $display("FAIL err_flag[%0d]: got %0b want 1", i, err); end
      if (err_code !== t_code[i]) begin n_fail++; $display("FAIL err_code[%0d]: got %0b want %0b", i, err_code, t_code[i]); end
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL err_valid[%0d]: got %0b want 0", i, out_valid); end
      clr_pulse();
    end
    n_checks++;
    if (got_q.size() !== 0) begin n_fail++; $display("FAIL err_no_output: got %0d words want 0", got_q.size()); end
  endtask

  task automatic test_random();
    bit ok;
    logic [63:0] e, g;
    logic [6:0] opcs[4] = '{7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011};
    done = 1'b0;
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          logic [6:0] o; logic [2:0] f; logic [4:0] d, a, b; logic [31:0] im; int v;
          o = opcs[$urandom_range(0, 3)]; f = 3'($urandom); d = 5'($urandom);
          a = 5'($urandom); b = 5'($urandom);
          v = int'($urandom_range(0, 4095)) - 2048;
          if (o == 7'b1100011) v = v * 2;
          im = 32'(v);
          exp_q.push_back({model_word(o, f, d, a, b, im), exp_addr}); exp_addr += 4;
          send(o, f, d, a, b, im);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1)); end
      end
    join
    out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      wait_got(ok); e = exp_q.pop_front(); n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rnd_timeout: no output, want %h", e); end
      else begin g = got_q.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL rnd_word: got %h want %h", g, e); end end
    end
  endtask

  task automatic test_reset_clear();
    bit ok;
    logic [63:0] e, g;
    @(posedge clk); #1 out_ready = 1'b0;
    send(7'b0010011, 3'd1, 5'd2, 5'd3, 5'd0, 32'd9);
    @(posedge clk); #1 rst = 1'b1;
    #1 n_checks += 3;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %0b want 0", out_valid); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL async_rst_ready: got %0b want 0", in_ready); end
    if (out_addr !== BASE) begin n_fail++; $display("FAIL async_rst_addr: got %h want %h", out_addr, BASE); end
    @(posedge clk); #1 rst = 1'b0; exp_addr = BASE;
    out_ready = 1'b1;
    exp_q.push_back({model_word(7'b0000011, 3'd2, 5'd8, 5'd9, 5'd0, 32'd40), exp_addr}); exp_addr += 4;
    send(7'b0000011, 3'd2, 5'd8, 5'd9, 5'd0, 32'd40);
    @(posedge clk); #1 out_ready = 1'b0;
    send(7'b0010011, 3'd4, 5'd1, 5'd1, 5'd0, 32'd7);
    clr = 1'b1; out_ready = 1'b1;
    @(negedge clk); n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready: got %0b want 0", in_ready); end
    @(posedge clk); #1 clr = 1'b0; exp_addr = BASE;
    @(negedge clk); n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %0b want 0", out_valid); end
    @(posedge clk); #1;
    exp_q.push_back({model_word(7'b0100011, 3'd0, 5'd0, 5'd4, 5'd5, 32'd12), exp_addr}); exp_addr += 4;
    send(7'b0100011, 3'd0, 5'd0, 5'd4, 5'd5, 32'd12);
    while (exp_q.size() > 0) begin
      wait_got(ok); e = exp_q.pop_front(); n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rc_timeout: no output, want %h", e); end
      else begin g = got_q.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL rc_word: got %h want %h", g, e); end end
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (got_q.size() !== 0) begin n_fail++; $display("FAIL rc_extra: got %0d stray words want 0", got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_back_to_back();
    test_errors();
    test_random();
    test_reset_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter: BASE_ADDR, default 32'h0000_0000, first instruction-memory write address after reset or clr.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 clr  in  1  synchronous clear of FSM, error and address counter.
REQ-005 in_valid  in  1  field bundle valid.
REQ-006 in_ready  out  1  encoder accepts bundle this cycle.
REQ-007 in_opcode  in  7; in_funct3  in  3; in_rd, in_rs1, in_rs2  in  5 each: instruction fields.
REQ-008 in_imm  in  32  two's-complement immediate, byte offset for branches.
REQ-009 out_valid  out  1; out_ready  in  1: output handshake.
REQ-010 out_inst  out  32  encoded instruction word.
REQ-011 out_addr  out  32  write address paired with out_inst.
REQ-012 err  out  1  sticky error flag; err_code  out  2: 01 illegal opcode, 10 immediate out of range, 11 branch offset odd.

Function
REQ-013 Formats: I for opcodes 0000011, 0010011; S for 0100011; B for 1100011; every other opcode is illegal.
REQ-014 I word = {imm[11:0], rs1, funct3, rd, opcode}.
REQ-015 S word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-016 B word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}; rd ignored.
REQ-017 Legal range: I/S -2048..2047; B -4096..4094 with imm[0]=0; check precedence opcode > range > odd.
REQ-018 FSM states: EMPTY, FULL, HALT; single output register; latency 1 cycle from input handshake to out_valid.
REQ-019 in_ready = (EMPTY) or (FULL and out_ready); 0 in HALT and in any cycle clr=1.
REQ-020 Legal accepted bundle: EMPTY->FULL, or FULL->FULL with simultaneous drain (full throughput, no bubble).
REQ-021 Illegal accepted bundle: handshake completes, word discarded, err=1, err_code set, next state HALT; a coincident output handshake of the previous word still completes.
REQ-022 FULL with out_ready=1 and no input: -> EMPTY.
REQ-023 out_inst/out_addr stable while out_valid=1 and out_ready=0.
REQ-024 out_addr increments by 4 after each output handshake; wraps 0xFFFF_FFFC -> 0x0000_0000 without error.
REQ-025 HALT: out_valid=0, in_ready=0, err held until clr or rst.
REQ-026 clr=1 (any state, priority over handshakes): next state EMPTY, pending word dropped, err=0, err_code=0, address=BASE_ADDR.

Reset
REQ-027 rst asserted: immediately state EMPTY, out_valid=0, out_inst=0, out_addr=BASE_ADDR, err=0, err_code=0; in_ready=0 while rst high.
REQ-028 Reset mid-transfer discards any held word; first post-reset word gets BASE_ADDR.

Structure
REQ-029 Shared package holds opcode constants (LOAD, OP_IMM, STORE, BRANCH), format enum (I, S, B, ILLEGAL), err_code constants, FSM state enum.
REQ-030 One combinational sub-module inst_pack: fields + format -> word plus range/alignment flags; FSM, output register and address counter in inst_encoder.

Verification
REQ-031 opcode 0010011, rd=1, rs1=0, funct3=0, imm=5 -> out_inst 0x00500093, out_addr BASE_ADDR, one cycle later.
REQ-032 opcode 0100011, funct3=010, rs1=1, rs2=2, imm=8 -> 0x0020A423; opcode 1100011, funct3=0, rs1=1, rs2=2, imm=-4 -> 0xFE208EE3; addresses +0, +4.
REQ-033 out_ready=0 with three back-to-back bundles -> first held stable, in_ready=0 after first; releasing out_ready drains all three, addresses consecutive.
REQ-034 I-type imm=2048 -> no output, err=1, err_code=10, in_ready=0; B imm=6 after clr accepted; B imm=3 -> err_code=11; opcode 0110111 -> err_code=01.
REQ-035 BASE_ADDR=0xFFFF_FFF8, three words -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-036 rst pulse while FULL, and clr while FULL with out_ready=1 -> no handshake that cycle, out_valid=0 next, next word at BASE_ADDR.
